// File: rtl/execute_cycle_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle_if
// Brief    : EX-stage inputs and EX/MEM outputs of the RV32I execute stage.
// Revision : 1.0
// ============================================================================
interface execute_cycle_if;
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [4:0]  RD_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M;
    logic [31:0] WriteDataM;
    logic [31:0] ALU_ResultM;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface
`default_nettype wire

// File: rtl/execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : execute_cycle
// Brief    : RV32I EX stage: ALU, beq resolution, EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
module execute_cycle (
    input  wire logic      clk,
    input  wire logic      rst,
    execute_cycle_if.slave ex
);
    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    logic [31:0] w_src_b;
    logic [31:0] w_alu_result;
    logic        w_zero;

    assign w_src_b = ex.ALUSrcE ? ex.Imm_Ext_E : ex.RD2_E;

    always_comb begin
        w_alu_result = 32'd0;
        case (ex.ALUControlE)
            C_ALU_ADD: w_alu_result = ex.RD1_E + w_src_b;
            C_ALU_SUB: w_alu_result = ex.RD1_E - w_src_b;
            C_ALU_AND: w_alu_result = ex.RD1_E & w_src_b;
            C_ALU_OR:  w_alu_result = ex.RD1_E | w_src_b;
            C_ALU_SLT: w_alu_result = {31'd0, $signed(ex.RD1_E) < $signed(w_src_b)};
            default:   w_alu_result = 32'd0;
        endcase
    end

    assign w_zero       = (w_alu_result == 32'd0);
    // Branch decision and target bypass the pipeline register and ignore rst.
    assign ex.PCSrcE    = ex.BranchE & w_zero;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    logic        regwrite_d,  regwrite_q;
    logic        memwrite_d,  memwrite_q;
    logic        resultsrc_d, resultsrc_q;
    logic [4:0]  rd_d,        rd_q;
    logic [31:0] pcplus4_d,   pcplus4_q;
    logic [31:0] writedata_d, writedata_q;
    logic [31:0] aluresult_d, aluresult_q;

    assign regwrite_d  = ex.RegWriteE;
    assign memwrite_d  = ex.MemWriteE;
    assign resultsrc_d = ex.ResultSrcE;
    assign rd_d        = ex.RD_E;
    assign pcplus4_d   = ex.PCPlus4E;
    assign writedata_d = ex.RD2_E;
    assign aluresult_d = w_alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= 5'd0;
            pcplus4_q   <= 32'd0;
            writedata_q <= 32'd0;
            aluresult_q <= 32'd0;
        end else begin
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pcplus4_q   <= pcplus4_d;
            writedata_q <= writedata_d;
            aluresult_q <= aluresult_d;
        end
    end

    assign ex.RegWriteM   = regwrite_q;
    assign ex.MemWriteM   = memwrite_q;
    assign ex.ResultSrcM  = resultsrc_q;
    assign ex.RD_M        = rd_q;
    assign ex.PCPlus4M    = pcplus4_q;
    assign ex.WriteDataM  = writedata_q;
    assign ex.ALU_ResultM = aluresult_q;
endmodule
`default_nettype wire

// File: tb/tb_execute_cycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_cycle
// Brief    : Scoreboard bench for execute_cycle with directed + random vectors.
// Revision : 1.0
// ============================================================================
module tb_execute_cycle;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_cycle_if ifc ();

    execute_cycle dut (
        .clk (clk),
        .rst (rst),
        .ex  (ifc)
    );

    typedef struct packed {
        logic        rst;
        logic        regw;
        logic        alusrc;
        logic        memw;
        logic        ressrc;
        logic        br;
        logic [2:0]  ctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } stim_t;

    typedef struct packed {
        logic        regw;
        logic        memw;
        logic        ressrc;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wd;
        logic [31:0] alu;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference ALU from the instruction semantics; SLT decided by sign bits.
    function automatic logic [31:0] alu_ref(input logic [2:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        logic lt;
        if (a[31] != b[31]) lt = a[31];
        else                lt = (a < b);
        case (ctl)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return lt ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input stim_t s);
        logic [31:0] srcb;
        logic [31:0] res;
        exp_t        e;
        @(negedge clk);
        rst             = s.rst;
        ifc.RegWriteE   = s.regw;
        ifc.ALUSrcE     = s.alusrc;
        ifc.MemWriteE   = s.memw;
        ifc.ResultSrcE  = s.ressrc;
        ifc.BranchE     = s.br;
        ifc.ALUControlE = s.ctl;
        ifc.RD1_E       = s.rd1;
        ifc.RD2_E       = s.rd2;
        ifc.Imm_Ext_E   = s.imm;
        ifc.RD_E        = s.rd;
        ifc.PCE         = s.pc;
        ifc.PCPlus4E    = s.pc4;
        #1;
        srcb = s.alusrc ? s.imm : s.rd2;
        res  = alu_ref(s.ctl, s.rd1, srcb);
        chk("PCSrcE", 32'(ifc.PCSrcE), 32'(s.br && (res == 32'd0)));
        chk("PCTargetE", ifc.PCTargetE, s.pc + s.imm);
        if (s.rst) e = '0;
        else       e = '{regw: s.regw, memw: s.memw, ressrc: s.ressrc, rd: s.rd,
                         pc4: s.pc4, wd: s.rd2, alu: res};
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("RegWriteM",   32'(ifc.RegWriteM),  32'(e.regw));
            chk("MemWriteM",   32'(ifc.MemWriteM),  32'(e.memw));
            chk("ResultSrcM",  32'(ifc.ResultSrcM), 32'(e.ressrc));
            chk("RD_M",        32'(ifc.RD_M),       32'(e.rd));
            chk("PCPlus4M",    ifc.PCPlus4M,   e.pc4);
            chk("WriteDataM",  ifc.WriteDataM, e.wd);
            chk("ALU_ResultM", ifc.ALU_ResultM, e.alu);
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;

        // Reset with arbitrary data present.
        s = '0; s.rst = 1'b1; s.regw = 1'b1; s.memw = 1'b1; s.ressrc = 1'b1;
        s.rd1 = 32'h1234_5678; s.rd2 = 32'h9abc_def0; s.imm = 32'h40; s.rd = 5'd9;
        s.pc = 32'h200; s.pc4 = 32'h204;
        drive(s);

        s = '0; s.rd1 = 5; s.rd2 = 3; s.regw = 1'b1; s.rd = 5'd7;             drive(s);
        s = '0; s.rd1 = 5; s.imm = 4; s.alusrc = 1'b1; s.rd2 = 32'hdead;       drive(s);
        s = '0; s.rd1 = 5; s.rd2 = 5; s.ctl = 3'd1; s.br = 1'b1;
        s.pc = 32'h100; s.imm = 32'h10;                                         drive(s);
        s.rd2 = 6;                                                              drive(s);
        s = '0; s.rd1 = 32'hF0F0_F0F0; s.rd2 = 32'hFF00_FF00; s.ctl = 3'd2;    drive(s);
        s = '0; s.rd1 = 32'hF0F0_F0F0; s.rd2 = 32'h0F0F_0F0F; s.ctl = 3'd3;    drive(s);
        s = '0; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1;                              drive(s);
        s = '0; s.rd1 = 32'hFFFF_FFFF; s.rd2 = 1; s.ctl = 3'd5;                drive(s);
        s = '0; s.rd1 = 1; s.rd2 = 32'hFFFF_FFFF; s.ctl = 3'd5;                drive(s);
        s = '0; s.memw = 1'b1; s.ressrc = 1'b1; s.pc4 = 32'h104; s.rd2 = 32'h55; drive(s);
        s = '0; s.rd1 = 32'h77; s.rd2 = 32'h88; s.ctl = 3'd6; s.br = 1'b1;    drive(s);
        // Reset in the middle of a stream discards the in-flight instruction.
        s = '0; s.rst = 1'b1; s.rd1 = 9; s.rd2 = 9; s.ctl = 3'd1; s.br = 1'b1;
        s.regw = 1'b1; s.rd = 5'd3;                                             drive(s);

        for (int i = 0; i < 400; i++) begin
            s.rst    = ($urandom_range(0, 19) == 0);
            s.regw   = 1'($urandom);
            s.alusrc = 1'($urandom);
            s.memw   = 1'($urandom);
            s.ressrc = 1'($urandom);
            s.br     = 1'($urandom);
            s.ctl    = 3'($urandom_range(0, 7));
            s.rd1    = $urandom;
            s.rd2    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.imm    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
            s.rd     = 5'($urandom);
            s.pc     = $urandom;
            s.pc4    = s.pc + 32'd4;
            drive(s);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
